// File: rtl/adc_sdram_writer.sv
// Packs 16-bit ADC samples into 32-bit words, buffers them in a FIFO and writes them to SDRAM over Avalon-MM.
// Define ADC_CAP_RING_EN for ring-buffer addressing; the capture then ends only on cap_stop.
module adc_sdram_writer #(
   parameter int FIFO_AW = 4
) (
   input  logic        in_clk_clk,
   input  logic        in_rst_reset,
   input  logic        cap_start,
   input  logic        cap_stop,
   input  logic [23:0] cap_base,
   input  logic [23:0] cap_len,
   input  logic        smp_valid,
   input  logic [15:0] smp_data,
   output logic        cap_busy,
   output logic        cap_done,
   output logic        cap_overflow,
   output logic [23:0] cap_wr_ptr,
   output logic [23:0] avm_address,
   output logic [3:0]  avm_byteenable_n,
   output logic        avm_chipselect,
   output logic [31:0] avm_writedata,
   output logic        avm_read_n,
   output logic        avm_write_n,
   input  logic        avm_waitrequest
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;

   logic [23:0]        base_r, len_r, push_cnt, push_cnt_inc, ptr_inc, wr_ptr_nxt;
   logic [15:0]        half;
   logic               have_half;
   logic [31:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] f_wp, f_rp, rd_nxt;
   logic [FIFO_AW:0]   count, cnt_ap;
   logic               start_acc, run, drain_done, accept, push, push_ok, full, req_nxt;

   assign avm_byteenable_n = 4'b0000;
   assign avm_read_n       = 1'b1;

   assign accept  = avm_chipselect & ~avm_waitrequest;
   assign full    = (count == FULL_CNT);
   assign push    = run & smp_valid & have_half;
   assign push_ok = push & ~full;
   // FIFO occupancy and head index once this cycle's accept has popped
   assign cnt_ap  = count - (FIFO_AW+1)'(accept);
   assign rd_nxt  = f_rp + FIFO_AW'(accept);
   assign req_nxt = (state != IDLE) && (cnt_ap != '0);

`ifdef ADC_CAP_RING_EN
   assign push_cnt_inc = (push_cnt == len_r - 24'd1) ? 24'd0 : push_cnt + 24'd1;
   assign ptr_inc      = (cap_wr_ptr == len_r - 24'd1) ? 24'd0 : cap_wr_ptr + 24'd1;
`else
   assign push_cnt_inc = push_cnt + 24'd1;
   assign ptr_inc      = cap_wr_ptr + 24'd1;
`endif
   assign wr_ptr_nxt = accept ? ptr_inc : cap_wr_ptr;

   always_ff @(posedge in_clk_clk) begin
      if (in_rst_reset) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (cap_start && cap_len != 24'd0) state_nxt = RUN;
         RUN: begin
`ifdef ADC_CAP_RING_EN
            if (cap_stop) state_nxt = DRAIN;
`else
            if (cap_stop || (push_ok && push_cnt_inc == len_r)) state_nxt = DRAIN;
`endif
         end
         DRAIN: if (cnt_ap == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start_acc  = (state == IDLE) && cap_start && (cap_len != 24'd0);
      run        = (state == RUN);
      drain_done = (state == DRAIN) && (cnt_ap == '0);
   end

   always_ff @(posedge in_clk_clk) begin
      if (push_ok) mem[f_wp] <= {smp_data, half};
   end

   always_ff @(posedge in_clk_clk) begin
      if (in_rst_reset) begin
         base_r       <= '0;
         len_r        <= '0;
         push_cnt     <= '0;
         half         <= '0;
         have_half    <= 1'b0;
         f_wp         <= '0;
         f_rp         <= '0;
         count        <= '0;
         cap_busy     <= 1'b0;
         cap_done     <= 1'b0;
         cap_overflow <= 1'b0;
         cap_wr_ptr   <= '0;
      end else begin
         cap_busy <= (state_nxt != IDLE);
         cap_done <= drain_done;
         if (start_acc) begin
            base_r       <= cap_base;
            len_r        <= cap_len;
            push_cnt     <= '0;
            have_half    <= 1'b0;
            f_wp         <= '0;
            f_rp         <= '0;
            count        <= '0;
            cap_overflow <= 1'b0;
            cap_wr_ptr   <= '0;
         end else begin
            // a half-filled word is dropped as soon as RUN is left
            if (run && smp_valid) begin
               if (!have_half) half <= smp_data;
               have_half <= ~have_half;
            end else if (!run) begin
               have_half <= 1'b0;
            end
            if (push && full) cap_overflow <= 1'b1;
            if (push_ok) begin
               f_wp     <= f_wp + 1'b1;
               push_cnt <= push_cnt_inc;
            end
            f_rp       <= rd_nxt;
            count      <= cnt_ap + (FIFO_AW+1)'(push_ok);
            cap_wr_ptr <= wr_ptr_nxt;
         end
      end
   end

   // bus outputs freeze while a request is stalled, otherwise track the post-pop head
   always_ff @(posedge in_clk_clk) begin
      if (in_rst_reset) begin
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_address    <= '0;
         avm_writedata  <= '0;
      end else if (!(avm_chipselect && avm_waitrequest)) begin
         avm_chipselect <= req_nxt;
         avm_write_n    <= ~req_nxt;
         if (req_nxt) begin
            avm_address   <= base_r + wr_ptr_nxt;
            avm_writedata <= mem[rd_nxt];
         end
      end
   end
endmodule

// File: tb/tb_adc_sdram_writer.sv
// Randomized self-checking bench for adc_sdram_writer against a word-list reference model.
module tb_adc_sdram_writer;
  localparam int AW = 2;
`ifdef ADC_CAP_RING_EN
  localparam bit RING = 1'b1;
`else
  localparam bit RING = 1'b0;
`endif

  logic        gclk = 1'b0, rst = 1'b1;
  logic        cap_start = 0, cap_stop = 0, smp_valid = 0, avm_waitrequest = 0;
  logic [23:0] cap_base = 0, cap_len = 0;
  logic [15:0] smp_data = 0;
  logic        cap_busy, cap_done, cap_overflow, avm_chipselect, avm_read_n, avm_write_n;
  logic [23:0] cap_wr_ptr, avm_address;
  logic [3:0]  avm_byteenable_n;
  logic [31:0] avm_writedata;

  adc_sdram_writer #(.FIFO_AW(AW)) dut (
    .in_clk_clk(gclk), .in_rst_reset(rst), .cap_start(cap_start), .cap_stop(cap_stop),
    .cap_base(cap_base), .cap_len(cap_len), .smp_valid(smp_valid), .smp_data(smp_data),
    .cap_busy(cap_busy), .cap_done(cap_done), .cap_overflow(cap_overflow), .cap_wr_ptr(cap_wr_ptr),
    .avm_address(avm_address), .avm_byteenable_n(avm_byteenable_n), .avm_chipselect(avm_chipselect),
    .avm_writedata(avm_writedata), .avm_read_n(avm_read_n), .avm_write_n(avm_write_n),
    .avm_waitrequest(avm_waitrequest));

  always #5 gclk = ~gclk;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: the ordered list of words the capture must write, and where
  bit          m_run, m_half, rnd_wait;
  logic [15:0] m_lo;
  int          m_words, done_cnt;
  logic [23:0] m_base, m_len;
  logic [23:0] exp_addr[$], acc_addr[$];
  logic [31:0] exp_data[$], acc_data[$];

  task automatic step();
    @(posedge gclk); #1;
    if (rnd_wait) avm_waitrequest = !avm_waitrequest && ($urandom_range(0, 3) == 0);
  endtask

  task automatic drive(input bit v, input logic [15:0] d);
    smp_valid = v; smp_data = d;
    if (m_run && v) begin
      if (m_half) begin
        exp_data.push_back({d, m_lo});
        exp_addr.push_back(m_base + 24'(RING ? (m_words % int'(m_len)) : m_words));
        m_words++; m_half = 0;
        if (!RING && m_words == int'(m_len)) m_run = 0;
      end else begin
        m_lo = d; m_half = 1;
      end
    end
    step();
    smp_valid = 0;
  endtask

  task automatic start_cap(input logic [23:0] b, input logic [23:0] l, input bit v, input bit stp);
    exp_addr.delete(); exp_data.delete(); acc_addr.delete(); acc_data.delete();
    done_cnt = 0;
    cap_base = b; cap_len = l; cap_start = 1; cap_stop = stp; smp_valid = v; smp_data = 16'hDEAD;
    step();
    cap_start = 0; cap_stop = 0; smp_valid = 0; cap_base = 24'h5A5A5A; cap_len = 24'd7;
    m_base = b; m_len = l; m_run = (l != 0); m_half = 0; m_words = 0;
  endtask

  task automatic stop_cap();
    cap_stop = 1; step(); cap_stop = 0;
    m_run = 0; m_half = 0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int i = 0;
    while (done_cnt == 0 && i < max) begin step(); i++; end
    chk({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (4) step();
  endtask

  task automatic check_writes(input string tag, input logic [23:0] ptr);
    int n = (acc_addr.size() < exp_addr.size()) ? acc_addr.size() : exp_addr.size();
    chk({tag, "_nwrites"}, acc_addr.size(), exp_addr.size());
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, acc_addr[i], exp_addr[i]);
      chk({tag, "_data"}, acc_data[i], exp_data[i]);
    end
    chk({tag, "_wr_ptr"}, cap_wr_ptr, ptr);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_end"}, cap_busy, 0);
  endtask

  // bus monitor: records accepts, checks stall stability and done/busy alignment
  bit          pstall = 0;
  logic [23:0] paddr;
  logic [31:0] pdata;
  always @(negedge gclk) begin
    if (pstall) begin
      chk("hold_cs", avm_chipselect, 1);
      chk("hold_addr", avm_address, paddr);
      chk("hold_data", avm_writedata, pdata);
    end
    pstall = !rst && avm_chipselect && avm_waitrequest;
    paddr = avm_address; pdata = avm_writedata;
    if (!rst && avm_chipselect && !avm_write_n && !avm_waitrequest) begin
      acc_addr.push_back(avm_address);
      acc_data.push_back(avm_writedata);
    end
    if (cap_done) begin
      done_cnt++;
      chk("busy_at_done", cap_busy, 0);
    end
  end

  initial begin
    logic [23:0] b, l;
    int tgt, j, cnt;
    bit found;
    rnd_wait = 0;
    repeat (3) step();
    @(negedge gclk);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_write_n", avm_write_n, 1);
    chk("rst_read_n", avm_read_n, 1);
    chk("rst_be_n", avm_byteenable_n, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_data", avm_writedata, 0);
    chk("rst_busy", cap_busy, 0);
    chk("rst_done", cap_done, 0);
    chk("rst_ovf", cap_overflow, 0);
    chk("rst_ptr", cap_wr_ptr, 0);
    rst = 0;
    step();

`ifndef ADC_CAP_RING_EN
    // one-shot directed: sample in start cycle ignored, start while busy ignored
    start_cap(24'h000100, 24'd4, 1, 0);
    chk("os_busy_rise", cap_busy, 1);
    drive(1, 16'h0001);
    drive(1, 16'h0002);
    @(negedge gclk); chk("lat_n1_cs", avm_chipselect, 0);
    step();
    @(negedge gclk); chk("lat_n2_cs", avm_chipselect, 1);
    step();
    cap_start = 1; cap_base = 24'h000999;
    drive(1, 16'h0003);
    cap_start = 0;
    for (int i = 4; i <= 9; i++) drive(1, 16'(i));
    wait_done("os", 200);
    check_writes("os", 24'd4);
    if (acc_data.size() == 4) begin
      chk("os_w0_data", acc_data[0], 32'h00020001);
      chk("os_w0_addr", acc_addr[0], 24'h000100);
      chk("os_w3_data", acc_data[3], 32'h00080007);
      chk("os_w3_addr", acc_addr[3], 24'h000103);
    end
`else
    // ring directed: 10 words into a 3-word region
    start_cap(24'h000010, 24'd3, 0, 0);
    for (int i = 1; i <= 20; i++) drive(1, 16'(i));
    stop_cap();
    wait_done("ring", 300);
    check_writes("ring", 24'd1);
    if (acc_addr.size() == 10) chk("ring_a3", acc_addr[3], 24'h000010);
`endif

    // stop mid-word
    start_cap(24'h004000, 24'd100, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 16'($urandom));
    stop_cap();
    wait_done("stop", 200);
    check_writes("stop", 24'd2);

    // address wrap at 2^24
    start_cap(24'hFFFFFF, 24'd2, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 16'($urandom));
    if (RING) stop_cap();
    wait_done("wrap", 200);
    check_writes("wrap", RING ? 24'd0 : 24'd2);
    if (acc_addr.size() == 2) begin
      chk("wrap_a0", acc_addr[0], 24'hFFFFFF);
      chk("wrap_a1", acc_addr[1], 24'h000000);
    end

    // randomized captures with short waitrequest pulses
    for (int t = 0; t < 6; t++) begin
      b = 24'($urandom); l = 24'($urandom_range(1, 6));
      tgt = RING ? $urandom_range(1, 3 * int'(l)) : int'(l);
      rnd_wait = 1;
      start_cap(b, l, $urandom_range(0, 1), 0);
      cnt = 0;
      while (((!RING && m_run) || (RING && m_words < tgt)) && cnt < 400) begin
        drive($urandom_range(0, 2) != 0, 16'($urandom)); cnt++;
      end
      for (int i = 0; i < 3; i++) drive(1, 16'($urandom));
      if (RING) stop_cap();
      wait_done("rnd", 300);
      rnd_wait = 0; avm_waitrequest = 0; step();
      check_writes("rnd", RING ? 24'(m_words % int'(l)) : l);
    end

    // sustained stall with a 4-word FIFO; start and stop together, start wins
    avm_waitrequest = 1;
    start_cap(24'h000200, 24'd100, 0, 1);
    chk("start_wins_busy", cap_busy, 1);
    for (int i = 0; i < 24; i++) drive(1, 16'($urandom));
    avm_waitrequest = 0;
    for (int i = 0; i < 10; i++) drive(1, 16'($urandom));
    stop_cap();
    wait_done("stall", 200);
    chk("stall_ovf", cap_overflow, 1);
    chk("stall_ptr", cap_wr_ptr, acc_addr.size());
    chk("stall_some_dropped", acc_addr.size() < exp_addr.size(), 1);
    j = 0;
    for (int k = 0; k < acc_addr.size(); k++) begin
      chk("stall_addr", acc_addr[k], 24'h000200 + 24'(k));
      found = 0;
      while (j < exp_data.size() && !found) begin
        if (exp_data[j] == acc_data[k]) found = 1;
        j++;
      end
      chk("stall_data_order", found, 1);
    end

    // len=0 start ignored; overflow stays sticky
    start_cap(24'h000300, 24'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge gclk);
      chk("len0_busy", cap_busy, 0);
      chk("len0_cs", avm_chipselect, 0);
      step();
    end
    chk("len0_ovf_kept", cap_overflow, 1);
    chk("len0_nwrites", acc_addr.size(), 0);

    // reset while a write is stalled
    avm_waitrequest = 1;
    start_cap(24'h000400, 24'd8, 0, 0);
    chk("start_clears_ovf", cap_overflow, 0);
    for (int i = 0; i < 4; i++) drive(1, 16'($urandom));
    cnt = 0;
    while (!avm_chipselect && cnt < 20) begin step(); cnt++; end
    chk("rstmid_stalled", avm_chipselect, 1);
    rst = 1;
    step();
    @(negedge gclk);
    chk("rstmid_cs", avm_chipselect, 0);
    chk("rstmid_write_n", avm_write_n, 1);
    chk("rstmid_busy", cap_busy, 0);
    chk("rstmid_ptr", cap_wr_ptr, 0);
    rst = 0; avm_waitrequest = 0;
    repeat (4) step();
    @(negedge gclk);
    chk("post_rst_cs", avm_chipselect, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
